escaner_teclado: RTL and testbench

ESCANER_TECLADO -- requirements
Module: escaner_teclado

---
 rtl/escaner_teclado_pkg.sv | 74 +++++++
 rtl/escaner_teclado_filtro_estable.sv | 43 ++++
 rtl/escaner_teclado.sv | 106 ++++++++++
 tb/tb_escaner_teclado.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/escaner_teclado_pkg.sv
// Shared calculator definitions: key codes, scanner states and small decode helpers.
// Used by the keypad scanner and by the reset/accumulator logic of the calculator.
`timescale 1ns/1ps
package escaner_teclado_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } estado_e;

  localparam logic [4:0] TECLA_0       = 5'd0;
  localparam logic [4:0] TECLA_1       = 5'd1;
  localparam logic [4:0] TECLA_2       = 5'd2;
  localparam logic [4:0] TECLA_3       = 5'd3;
  localparam logic [4:0] TECLA_4       = 5'd4;
  localparam logic [4:0] TECLA_5       = 5'd5;
  localparam logic [4:0] TECLA_6       = 5'd6;
  localparam logic [4:0] TECLA_7       = 5'd7;
  localparam logic [4:0] TECLA_8       = 5'd8;
  localparam logic [4:0] TECLA_9       = 5'd9;
  localparam logic [4:0] TECLA_A       = 5'd10;
  localparam logic [4:0] TECLA_B       = 5'd11;
  localparam logic [4:0] TECLA_C       = 5'd12;
  localparam logic [4:0] TECLA_D       = 5'd13;
  localparam logic [4:0] TECLA_AST     = 5'd14;
  localparam logic [4:0] TECLA_IGUAL   = 5'd15;
  localparam logic [4:0] TECLA_NINGUNA = 5'd31;

  // Exactly one bit set: a single key in the driven column.
  function automatic logic es_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] indice(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    case (v)
      4'b0001: r = 2'd0;
      4'b0010: r = 2'd1;
      4'b0100: r = 2'd2;
      4'b1000: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  function automatic logic [4:0] codigo_tecla(input logic [1:0] fila, input logic [1:0] col);
    logic [4:0] k;
    k = TECLA_NINGUNA;
    case ({fila, col})
      4'b00_00: k = TECLA_1;
      4'b00_01: k = TECLA_2;
      4'b00_10: k = TECLA_3;
      4'b00_11: k = TECLA_A;
      4'b01_00: k = TECLA_4;
      4'b01_01: k = TECLA_5;
      4'b01_10: k = TECLA_6;
      4'b01_11: k = TECLA_B;
      4'b10_00: k = TECLA_7;
      4'b10_01: k = TECLA_8;
      4'b10_10: k = TECLA_9;
      4'b10_11: k = TECLA_C;
      4'b11_00: k = TECLA_AST;
      4'b11_01: k = TECLA_0;
      4'b11_10: k = TECLA_IGUAL;
      4'b11_11: k = TECLA_D;
      default:  k = TECLA_NINGUNA;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/escaner_teclado_filtro_estable.sv
// Row synchronizer plus stable-cycle counter, shared by press and release debouncing.
// alcanzado flags the cycle in which the N-th consecutive matching cycle is seen.
`timescale 1ns/1ps
module filtro_estable #(
  parameter int N = 500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] din,
  input  logic       en,
  input  logic [3:0] patron,
  output logic [3:0] fs,
  output logic       igual,
  output logic       alcanzado
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] CMAX = CW'(N);

  logic [3:0]    s1;
  logic [CW-1:0] cnt;

  assign igual     = (fs == patron);
  assign alcanzado = en && igual && (cnt == CMAX - CW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      s1  <= 4'd0;
      fs  <= 4'd0;
      cnt <= '0;
    end else begin
      s1 <= din;
      fs <= s1;
      // Counts only while enabled and matching; saturates instead of wrapping.
      if (en && igual) begin
        if (cnt != CMAX) cnt <= cnt + CW'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/escaner_teclado.sv
// 4x4 keypad scanner: rotates column drive, debounces a single key press and its release,
// and reports the key code with a one-cycle event. estado exposes the FSM for observation.
`timescale 1ns/1ps
module escaner_teclado
  import escaner_teclado_pkg::*;
#(
  parameter int SCAN_DIV        = 50_000,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] filas,
  output logic [3:0] columnas,
  output logic [4:0] tecla,
  output logic       evento_tecla,
  output logic       tecla_presionada,
  output estado_e    estado
);

  localparam int DW = $clog2(SCAN_DIV) + 1;
  localparam logic [DW-1:0] DLAST = DW'(SCAN_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic [1:0]    col_idx;
  logic [3:0]    fila_lat;
  logic [3:0]    fs;
  logic          igual;
  logic          alcanzado;
  logic          filtro_en;
  logic [3:0]    filtro_patron;
  logic [3:0]    columnas_sig;

  // Press debouncing compares against the latched row; release compares against all-zero.
  assign filtro_en     = (estado == DEBOUNCE) || (estado == RELEASE);
  assign filtro_patron = (estado == RELEASE) ? 4'd0 : fila_lat;
  assign columnas_sig  = {columnas[2:0], columnas[3]};

  filtro_estable #(
    .N(DEBOUNCE_CYCLES)
  ) u_filtro (
    .clk       (clk),
    .reset     (reset),
    .din       (filas),
    .en        (filtro_en),
    .patron    (filtro_patron),
    .fs        (fs),
    .igual     (igual),
    .alcanzado (alcanzado)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      estado           <= SCAN;
      columnas         <= 4'b0001;
      tecla            <= TECLA_NINGUNA;
      evento_tecla     <= 1'b0;
      tecla_presionada <= 1'b0;
      div_cnt          <= '0;
      col_idx          <= 2'd0;
      fila_lat         <= 4'd0;
    end else begin
      evento_tecla <= 1'b0;
      case (estado)
        SCAN: begin
          if (div_cnt == DLAST) begin
            div_cnt <= '0;
            if (es_onehot(fs)) begin
              fila_lat <= fs;
              col_idx  <= indice(columnas);
              estado   <= DEBOUNCE;
            end else begin
              columnas <= columnas_sig;
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        DEBOUNCE: begin
          if (!igual) begin
            columnas <= columnas_sig;
            estado   <= SCAN;
          end else if (alcanzado) begin
            tecla            <= codigo_tecla(indice(fila_lat), col_idx);
            evento_tecla     <= 1'b1;
            tecla_presionada <= 1'b1;
            estado           <= HELD;
          end
        end
        HELD: begin
          if (fs == 4'd0) estado <= RELEASE;
        end
        RELEASE: begin
          if (fs != 4'd0) begin
            estado <= HELD;
          end else if (alcanzado) begin
            tecla_presionada <= 1'b0;
            columnas         <= columnas_sig;
            estado           <= SCAN;
          end
        end
        default: estado <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_escaner_teclado.sv
// Directed bench for escaner_teclado with SCAN_DIV=4, DEBOUNCE_CYCLES=8 and a modelled keypad.
`timescale 1ns/1ps
module tb_escaner_teclado;
  import escaner_teclado_pkg::*;

  logic       clk;
  logic       reset;
  logic [3:0] filas;
  logic [3:0] columnas;
  logic [4:0] tecla;
  logic       evento_tecla;
  logic       tecla_presionada;
  estado_e    estado;

  logic [1:0] key_r;
  logic [1:0] key_c;
  logic       key_on;
  logic [3:0] extra;

  int n_cmp;
  int n_err;
  int ev_total;
  logic [4:0] exp_q[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  escaner_teclado #(
    .SCAN_DIV        (4),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .filas            (filas),
    .columnas         (columnas),
    .tecla            (tecla),
    .evento_tecla     (evento_tecla),
    .tecla_presionada (tecla_presionada),
    .estado           (estado)
  );

  // Keypad model: a closed key connects its column drive to its row line.
  always_comb begin
    filas = extra;
    if (key_on && columnas[key_c]) filas[key_r] = 1'b1;
  end

  // Scoreboard: every event must match the next expected key code.
  always @(posedge clk) begin
    #2;
    if (evento_tecla === 1'b1) begin
      ev_total++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL event_unexpected: tecla=%0d, required no event", tecla);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        if (tecla !== e) begin
          n_err++;
          $display("FAIL event_code: tecla=%0d, required %0d", tecla, e);
        end
      end
    end
  end

  // driver tasks
  task automatic ciclos(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulsar(input logic [1:0] r, input logic [1:0] c);
    @(negedge clk);
    key_r  = r;
    key_c  = c;
    key_on = 1'b1;
  endtask

  task automatic soltar();
    @(negedge clk);
    key_on = 1'b0;
  endtask

  task automatic esperar_evento(input int max, output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    while (n < max && !ok) begin
      @(negedge clk);
      n++;
      if (evento_tecla === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic esperar_libre(input int max, output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    while (n < max && !ok) begin
      @(negedge clk);
      n++;
      if (tecla_presionada === 1'b0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ciclos(3);
    n_cmp++;
    if ({columnas, tecla, evento_tecla, tecla_presionada} !== {4'b0001, 5'd31, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_values: col=%b tecla=%0d ev=%b pres=%b, required 0001/31/0/0",
               columnas, tecla, evento_tecla, tecla_presionada);
    end
    reset = 1'b0;
    ciclos(3);
    n_cmp++;
    if (columnas !== 4'b0001) begin
      n_err++;
      $display("FAIL scan_slot_hold: col=%b, required 0001", columnas);
    end
    ciclos(1);
    n_cmp++;
    if (columnas !== 4'b0010) begin
      n_err++;
      $display("FAIL scan_rotate: col=%b, required 0010", columnas);
    end
  endtask

  task automatic test_press_6();
    int n, ev0;
    bit ok;
    ev0 = ev_total;
    exp_q.push_back(5'd6);
    pulsar(2'd1, 2'd2);
    esperar_evento(8 + 16 + 3, n, ok);
    n_cmp++;
    if (!ok || tecla !== 5'd6 || tecla_presionada !== 1'b1) begin
      n_err++;
      $display("FAIL press6_accept: seen=%0d tecla=%0d pres=%b, required event tecla=6 pres=1",
               ok, tecla, tecla_presionada);
    end
    ciclos(30);
    soltar();
    ciclos(8);
    n_cmp++;
    if (tecla_presionada !== 1'b1) begin
      n_err++;
      $display("FAIL press6_pres_hold: pres=%b, required 1 for 8 cycles after release", tecla_presionada);
    end
    esperar_libre(20, n, ok);
    n_cmp++;
    if (!ok || n + 8 < 9 || n + 8 > 14) begin
      n_err++;
      $display("FAIL press6_release_time: cycles=%0d ok=%0d, required 9..14", n + 8, ok);
    end
    n_cmp++;
    if (ev_total - ev0 !== 1) begin
      n_err++;
      $display("FAIL press6_count: events=%0d, required 1", ev_total - ev0);
    end
  endtask

  task automatic test_bounce();
    int n, ev0;
    bit ok;
    ev0 = ev_total;
    pulsar(2'd3, 2'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i % 3 == 2) key_on = ~key_on;
    end
    n_cmp++;
    if (ev_total - ev0 !== 0) begin
      n_err++;
      $display("FAIL bounce_quiet: events=%0d, required 0", ev_total - ev0);
    end
    exp_q.push_back(5'd14);
    @(negedge clk);
    key_on = 1'b1;
    esperar_evento(60, n, ok);
    n_cmp++;
    if (!ok || tecla !== 5'd14) begin
      n_err++;
      $display("FAIL bounce_accept: seen=%0d tecla=%0d, required event tecla=14", ok, tecla);
    end
    soltar();
    esperar_libre(30, n, ok);
    n_cmp++;
    if (!ok || ev_total - ev0 !== 1) begin
      n_err++;
      $display("FAIL bounce_count: events=%0d free=%0d, required 1 event and release", ev_total - ev0, ok);
    end
  endtask

  task automatic test_multi();
    int ev0;
    logic [3:0] vistas;
    ev0 = ev_total;
    vistas = 4'd0;
    @(negedge clk);
    extra = 4'b0101;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      vistas = vistas | columnas;
    end
    n_cmp++;
    if (ev_total - ev0 !== 0 || vistas !== 4'b1111) begin
      n_err++;
      $display("FAIL multi_rows: events=%0d columns_seen=%b, required 0 and 1111", ev_total - ev0, vistas);
    end
    extra = 4'd0;
    ciclos(4);
  endtask

  task automatic test_back_to_back();
    int n, ev0;
    bit ok;
    ev0 = ev_total;
    exp_q.push_back(5'd5);
    pulsar(2'd1, 2'd1);
    esperar_evento(40, n, ok);
    n_cmp++;
    if (!ok || tecla !== 5'd5) begin
      n_err++;
      $display("FAIL b2b_first: seen=%0d tecla=%0d, required event tecla=5", ok, tecla);
    end
    ciclos(100);
    @(negedge clk);
    key_on = 1'b0;
    ciclos(4);
    key_on = 1'b1;
    ciclos(96);
    n_cmp++;
    if (tecla_presionada !== 1'b1 || ev_total - ev0 !== 1) begin
      n_err++;
      $display("FAIL b2b_glitch: pres=%b events=%0d, required 1 and 1", tecla_presionada, ev_total - ev0);
    end
    soltar();
    esperar_libre(30, n, ok);
    exp_q.push_back(5'd0);
    pulsar(2'd3, 2'd1);
    esperar_evento(40, n, ok);
    n_cmp++;
    if (!ok || tecla !== 5'd0) begin
      n_err++;
      $display("FAIL b2b_second: seen=%0d tecla=%0d, required event tecla=0", ok, tecla);
    end
    soltar();
    esperar_libre(30, n, ok);
    n_cmp++;
    if (ev_total - ev0 !== 2) begin
      n_err++;
      $display("FAIL b2b_count: events=%0d, required 2", ev_total - ev0);
    end
  endtask

  task automatic test_reset_debounce();
    int n, ev0;
    bit ok;
    ev0 = ev_total;
    pulsar(2'd0, 2'd0);
    ok = 1'b0;
    n = 0;
    while (n < 40 && !ok) begin
      @(negedge clk);
      n++;
      if (estado === DEBOUNCE) ok = 1'b1;
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL rstdb_reach: state=%0d, required DEBOUNCE within 40 cycles", estado);
    end
    ciclos(4);
    reset  = 1'b1;
    key_on = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if ({columnas, tecla, evento_tecla, tecla_presionada} !== {4'b0001, 5'd31, 1'b0, 1'b0}
        || estado !== SCAN) begin
      n_err++;
      $display("FAIL rstdb_values: col=%b tecla=%0d ev=%b pres=%b st=%0d, required 0001/31/0/0/SCAN",
               columnas, tecla, evento_tecla, tecla_presionada, estado);
    end
    ciclos(30);
    n_cmp++;
    if (ev_total - ev0 !== 0) begin
      n_err++;
      $display("FAIL rstdb_no_event: events=%0d, required 0", ev_total - ev0);
    end
  endtask

  task automatic test_hash();
    int n;
    bit ok;
    exp_q.push_back(5'd15);
    pulsar(2'd3, 2'd2);
    esperar_evento(40, n, ok);
    n_cmp++;
    if (!ok || tecla !== 5'd15) begin
      n_err++;
      $display("FAIL hash_accept: seen=%0d tecla=%0d, required event tecla=15", ok, tecla);
    end
    @(negedge clk);
    n_cmp++;
    if (evento_tecla !== 1'b0) begin
      n_err++;
      $display("FAIL hash_pulse_width: ev=%b one cycle later, required 0", evento_tecla);
    end
    ciclos(7);
    soltar();
    esperar_libre(30, n, ok);
    ciclos(10);
    n_cmp++;
    if (!ok || tecla !== 5'd15 || tecla_presionada !== 1'b0) begin
      n_err++;
      $display("FAIL hash_retain: free=%0d tecla=%0d pres=%b, required 1/15/0", ok, tecla, tecla_presionada);
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    ev_total = 0;
    reset    = 1'b1;
    key_r    = 2'd0;
    key_c    = 2'd0;
    key_on   = 1'b0;
    extra    = 4'd0;
    test_reset();
    test_press_6();
    test_bounce();
    test_multi();
    test_back_to_back();
    test_reset_debounce();
    test_hash();
    ciclos(5);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL missing_events: pending=%0d, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
